// File: rtl/ula_pkg.sv
// Shared ALU definitions: S operation codes, register-zero constant and
// default datapath widths used by the ID/EX stage and its forwarding units.
package ula_pkg;

   localparam int LARGURA_PADRAO   = 32;
   localparam int NREG_BITS_PADRAO = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam logic [3:0] ULA_ADD  = 4'b0000;
   localparam logic [3:0] ULA_SUB  = 4'b0001;
   localparam logic [3:0] ULA_AND  = 4'b0010;
   localparam logic [3:0] ULA_OR   = 4'b0011;
   localparam logic [3:0] ULA_XOR  = 4'b0100;
   localparam logic [3:0] ULA_NOR  = 4'b0101;
   localparam logic [3:0] ULA_SLT  = 4'b0110;
   localparam logic [3:0] ULA_SLL  = 4'b0111;
   localparam logic [3:0] ULA_SRL  = 4'b1000;
   localparam logic [3:0] ULA_SRA  = 4'b1001;
   localparam logic [3:0] ULA_PASS = 4'b1010;
   localparam logic [3:0] ULA_INC  = 4'b1011;

   // What the ID/EX register bank does on the next rising edge.
   typedef enum logic [1:0] {
      ACAO_CAPTURA = 2'b00,
      ACAO_MANTER  = 2'b01,
      ACAO_BOLHA   = 2'b10
   } acao_t;

   // True when a writeback candidate targets a non-zero source register.
   function automatic logic acerta_fonte(
      input logic       escreve,
      input logic [4:0] destino,
      input logic [4:0] fonte
   );
      return escreve & (destino == fonte) & (fonte != REG_ZERO);
   endfunction

endpackage

// File: rtl/unidade_forwarding.sv
// Combinational operand forwarding for one ALU source: the EX/MEM result
// has priority over the MEM/WB value, and register 0 is never forwarded.
module unidade_forwarding
   import ula_pkg::*;
#(
   parameter int LARGURA   = LARGURA_PADRAO,
   parameter int NREG_BITS = NREG_BITS_PADRAO
) (
   input  logic [NREG_BITS-1:0] fonte_i,
   input  logic [LARGURA-1:0]   valor_reg_i,
   input  logic                 mem_reg_write_i,
   input  logic [NREG_BITS-1:0] mem_rd_i,
   input  logic [LARGURA-1:0]   mem_resultado_i,
   input  logic                 wb_reg_write_i,
   input  logic [NREG_BITS-1:0] wb_rd_i,
   input  logic [LARGURA-1:0]   wb_dado_i,
   output logic [LARGURA-1:0]   valor_fwd_o
);

   logic acerta_mem_s;
   logic acerta_wb_s;

   assign acerta_mem_s = acerta_fonte(mem_reg_write_i, mem_rd_i, fonte_i);
   assign acerta_wb_s  = acerta_fonte(wb_reg_write_i, wb_rd_i, fonte_i);

   // Select the youngest in-flight value for this source, else the registered one.
   always_comb begin
      valor_fwd_o = valor_reg_i;
      if (acerta_mem_s) begin
         valor_fwd_o = mem_resultado_i;
      end else if (acerta_wb_s) begin
         valor_fwd_o = wb_dado_i;
      end else begin
         valor_fwd_o = valor_reg_i;
      end
   end

endmodule

// File: rtl/estagio_id_ex.sv
// ID/EX pipeline register feeding the ALU. Captures decoded operands and
// control, bypasses same-cycle register-file writes at capture, forwards
// MEM/WB results onto the operands, inserts one bubble on a load-use hazard
// and kills the wrong-path instruction when the branch in EX is taken.
module estagio_id_ex
   import ula_pkg::*;
#(
   parameter int LARGURA   = LARGURA_PADRAO,
   parameter int NREG_BITS = NREG_BITS_PADRAO
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 hold,
   input  logic                 flush,
   input  logic                 id_valid,
   input  logic [NREG_BITS-1:0] id_rs,
   input  logic [NREG_BITS-1:0] id_rt,
   input  logic [NREG_BITS-1:0] id_rd,
   input  logic                 id_usa_rs,
   input  logic                 id_usa_rt,
   input  logic [LARGURA-1:0]   id_dado1,
   input  logic [LARGURA-1:0]   id_dado2,
   input  logic [LARGURA-1:0]   id_imm,
   input  logic                 id_usa_imm,
   input  logic [3:0]           id_op_ula,
   input  logic                 id_branch,
   input  logic                 id_mem_read,
   input  logic                 id_mem_write,
   input  logic                 id_reg_write,
   input  logic                 mem_reg_write,
   input  logic [NREG_BITS-1:0] mem_rd,
   input  logic [LARGURA-1:0]   mem_resultado,
   input  logic                 wb_reg_write,
   input  logic [NREG_BITS-1:0] wb_rd,
   input  logic [LARGURA-1:0]   wb_dado,
   output logic                 stall_out,
   output logic [LARGURA-1:0]   ex_dado1,
   output logic [LARGURA-1:0]   ex_dado2,
   output logic [3:0]           ex_s,
   output logic                 ex_enable,
   output logic                 ex_branch,
   output logic [LARGURA-1:0]   ex_dado_store,
   output logic [NREG_BITS-1:0] ex_rd,
   output logic                 ex_mem_read,
   output logic                 ex_mem_write,
   output logic                 ex_reg_write
);

   // Register bank (current / next state)
   logic                 valid_q,     valid_d;
   logic [NREG_BITS-1:0] rs_q,        rs_d;
   logic [NREG_BITS-1:0] rt_q,        rt_d;
   logic [NREG_BITS-1:0] rd_q,        rd_d;
   logic [LARGURA-1:0]   dado1_q,     dado1_d;
   logic [LARGURA-1:0]   dado2_q,     dado2_d;
   logic [LARGURA-1:0]   imm_q,       imm_d;
   logic                 usa_imm_q,   usa_imm_d;
   logic [3:0]           op_q,        op_d;
   logic                 branch_q,    branch_d;
   logic                 mem_read_q,  mem_read_d;
   logic                 mem_write_q, mem_write_d;
   logic                 reg_write_q, reg_write_d;

   logic                 hazard_s;
   acao_t                acao_s;
   logic [LARGURA-1:0]   cap_dado1_s;
   logic [LARGURA-1:0]   cap_dado2_s;
   logic [LARGURA-1:0]   fwd1_s;
   logic [LARGURA-1:0]   fwd2_s;

   // Load in EX whose destination is read by the instruction sitting in ID.
   always_comb begin
      hazard_s = valid_q & mem_read_q & (rd_q != REG_ZERO) & id_valid &
                 ((id_usa_rs & (id_rs == rd_q)) | (id_usa_rt & (id_rt == rd_q)));
   end

   // A taken branch kills the ID instruction anyway, so no stall is requested then.
   always_comb begin
      stall_out = hazard_s & ~flush;
   end

   // Per-edge priority: hold keeps everything, flush and load-use both bubble.
   always_comb begin
      acao_s = ACAO_CAPTURA;
      if (hold) begin
         acao_s = ACAO_MANTER;
      end else if (flush) begin
         acao_s = ACAO_BOLHA;
      end else if (hazard_s) begin
         acao_s = ACAO_BOLHA;
      end else begin
         acao_s = ACAO_CAPTURA;
      end
   end

   // Register-file write and read in the same cycle: take the value being written.
   always_comb begin
      cap_dado1_s = id_dado1;
      cap_dado2_s = id_dado2;
      if (acerta_fonte(wb_reg_write, wb_rd, id_rs)) begin
         cap_dado1_s = wb_dado;
      end else begin
         cap_dado1_s = id_dado1;
      end
      if (acerta_fonte(wb_reg_write, wb_rd, id_rt)) begin
         cap_dado2_s = wb_dado;
      end else begin
         cap_dado2_s = id_dado2;
      end
   end

   // Next-state selection for the whole register bank.
   always_comb begin
      valid_d     = valid_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      rd_d        = rd_q;
      dado1_d     = dado1_q;
      dado2_d     = dado2_q;
      imm_d       = imm_q;
      usa_imm_d   = usa_imm_q;
      op_d        = op_q;
      branch_d    = branch_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      reg_write_d = reg_write_q;
      case (acao_s)
         ACAO_MANTER: begin
            valid_d = valid_q;
         end
         ACAO_CAPTURA: begin
            valid_d     = id_valid;
            rs_d        = id_rs;
            rt_d        = id_rt;
            rd_d        = id_rd;
            dado1_d     = cap_dado1_s;
            dado2_d     = cap_dado2_s;
            imm_d       = id_imm;
            usa_imm_d   = id_usa_imm;
            op_d        = id_op_ula;
            branch_d    = id_valid & id_branch;
            mem_read_d  = id_valid & id_mem_read;
            mem_write_d = id_valid & id_mem_write;
            reg_write_d = id_valid & id_reg_write;
         end
         ACAO_BOLHA: begin
            valid_d     = 1'b0;
            rs_d        = '0;
            rt_d        = '0;
            rd_d        = '0;
            dado1_d     = '0;
            dado2_d     = '0;
            imm_d       = '0;
            usa_imm_d   = 1'b0;
            op_d        = ULA_ADD;
            branch_d    = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            reg_write_d = 1'b0;
         end
         default: begin
            valid_d     = 1'b0;
            rs_d        = '0;
            rt_d        = '0;
            rd_d        = '0;
            dado1_d     = '0;
            dado2_d     = '0;
            imm_d       = '0;
            usa_imm_d   = 1'b0;
            op_d        = ULA_ADD;
            branch_d    = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            reg_write_d = 1'b0;
         end
      endcase
   end

   // ID/EX register bank with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q     <= 1'b0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         dado1_q     <= '0;
         dado2_q     <= '0;
         imm_q       <= '0;
         usa_imm_q   <= 1'b0;
         op_q        <= ULA_ADD;
         branch_q    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         reg_write_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         dado1_q     <= dado1_d;
         dado2_q     <= dado2_d;
         imm_q       <= imm_d;
         usa_imm_q   <= usa_imm_d;
         op_q        <= op_d;
         branch_q    <= branch_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         reg_write_q <= reg_write_d;
      end
   end

   unidade_forwarding #(
      .LARGURA   (LARGURA),
      .NREG_BITS (NREG_BITS)
   ) u_fwd_rs (
      .fonte_i         (rs_q),
      .valor_reg_i     (dado1_q),
      .mem_reg_write_i (mem_reg_write),
      .mem_rd_i        (mem_rd),
      .mem_resultado_i (mem_resultado),
      .wb_reg_write_i  (wb_reg_write),
      .wb_rd_i         (wb_rd),
      .wb_dado_i       (wb_dado),
      .valor_fwd_o     (fwd1_s)
   );

   unidade_forwarding #(
      .LARGURA   (LARGURA),
      .NREG_BITS (NREG_BITS)
   ) u_fwd_rt (
      .fonte_i         (rt_q),
      .valor_reg_i     (dado2_q),
      .mem_reg_write_i (mem_reg_write),
      .mem_rd_i        (mem_rd),
      .mem_resultado_i (mem_resultado),
      .wb_reg_write_i  (wb_reg_write),
      .wb_rd_i         (wb_rd),
      .wb_dado_i       (wb_dado),
      .valor_fwd_o     (fwd2_s)
   );

   // ALU operand 2 is the immediate or the forwarded rt value.
   always_comb begin
      ex_dado2 = fwd2_s;
      if (usa_imm_q) begin
         ex_dado2 = imm_q;
      end else begin
         ex_dado2 = fwd2_s;
      end
   end

   assign ex_dado1      = fwd1_s;
   assign ex_dado_store = fwd2_s;
   assign ex_s          = op_q;
   assign ex_enable     = valid_q;
   assign ex_branch     = branch_q;
   assign ex_rd         = rd_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_mem_write  = mem_write_q;
   assign ex_reg_write  = reg_write_q;

endmodule
